// File: rtl/register_bank_arbiter_pkg.sv
// Shared definitions for register_bank_arbiter: FSM state encoding, default sizes and the
// round-robin pointer advance helper.
package register_bank_arbiter_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_N_REQ = 4;
  localparam int unsigned DEF_IDX_W = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } state_e;

  // Next search start after granting idx; wraps from n-1 back to 0.
  function automatic int unsigned rr_next(int unsigned idx, int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/register_bank_arbiter_rr_pick.sv
// rr_pick: combinational masked round-robin picker. Scans req starting at ptr, wrapping
// modulo N_REQ, and returns the first set bit as one-hot grant plus binary index.
module register_bank_arbiter_rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int unsigned cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr) + k) % N_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/register_bank_arbiter.sv
// Shares one register_bank write port among N_REQ requesters with registered wr_en/data and a
// one-cycle ack. Round-robin by default; define ARB_FIXED_PRIO_EN for lowest-index-wins.
module register_bank_arbiter
  import register_bank_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_REQ = DEF_N_REQ,
  parameter int unsigned IDX_W = DEF_IDX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       ack,
  output logic                   bank_wr_en,
  output logic [WIDTH-1:0]       bank_in,
  output logic [IDX_W-1:0]       grant_idx,
  output logic                   busy
);

  state_e            state_q;
  logic [N_REQ-1:0]  avail;
  logic [N_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W-1:0]  pick_ptr;
  logic              pick_any;
  logic [WIDTH-1:0]  win_data;

  // The requester being acked this cycle must not win again for the same transfer.
  assign avail = req & ~ack;
  assign busy  = (state_q == ST_WRITE);

  register_bank_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req   (avail),
    .ptr   (pick_ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (pick_grant[i]) win_data |= req_data[i*WIDTH +: WIDTH];
    end
  end

  // IDLE and WRITE share the same transition rule: any available request issues a write,
  // otherwise fall back to IDLE. bank_in/grant_idx hold their last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ack        <= '0;
      bank_wr_en <= 1'b0;
      bank_in    <= '0;
      grant_idx  <= '0;
    end else if (pick_any) begin
      state_q    <= ST_WRITE;
      ack        <= pick_grant;
      bank_wr_en <= 1'b1;
      bank_in    <= win_data;
      grant_idx  <= pick_idx;
    end else begin
      state_q    <= ST_IDLE;
      ack        <= '0;
      bank_wr_en <= 1'b0;
    end
  end

`ifdef ARB_FIXED_PRIO_EN
  assign pick_ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (pick_any) begin
      ptr_q <= IDX_W'(rr_next(32'(pick_idx), N_REQ));
    end
  end

  assign pick_ptr = ptr_q;
`endif

endmodule

// File: tb/tb_register_bank_arbiter.sv
// Self-checking bench for register_bank_arbiter: directed vector table, hand sequences and a
// randomized requester population checked against a behavioural arbitration model.
module tb_register_bank_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    ack;
  logic            bank_wr_en;
  logic [W-1:0]    bank_in;
  logic [IW-1:0]   grant_idx;
  logic            busy;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the arbiter outputs.
  logic [N-1:0] m_ack;
  logic         m_wr;
  logic [W-1:0] m_in;
  int           m_idx;
  int           m_ptr;
  logic         m_rst;

  // Stand-in for the register_bank storage register.
  logic [W-1:0] bank_q;

  always #5 clk = ~clk;

  register_bank_arbiter #(
    .WIDTH (W),
    .N_REQ (N),
    .IDX_W (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .bank_wr_en (bank_wr_en),
    .bank_in    (bank_in),
    .grant_idx  (grant_idx),
    .busy       (busy)
  );

  always @(posedge clk) begin
    if (rst) bank_q <= '0;
    else if (bank_wr_en) bank_q <= bank_in;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model of one clock edge using the inputs present at that edge.
  task automatic model_edge();
    logic [N-1:0] avail;
    int win;
    m_rst = rst;
    if (rst) begin
      m_ack = '0; m_wr = 1'b0; m_in = '0; m_idx = 0; m_ptr = 0;
      return;
    end
    avail = req & ~m_ack;
    win = -1;
    for (int k = 0; k < N; k++) begin
      int c;
`ifdef ARB_FIXED_PRIO_EN
      c = k;
`else
      c = (m_ptr + k) % N;
`endif
      if (win < 0 && avail[c]) win = c;
    end
    if (win >= 0) begin
      m_ack = '0;
      m_ack[win] = 1'b1;
      m_wr  = 1'b1;
      m_in  = req_data[win*W +: W];
      m_idx = win;
      m_ptr = (win + 1) % N;
    end else begin
      m_ack = '0;
      m_wr  = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("ack", 32'(ack), 32'(m_ack));
    check("bank_wr_en", 32'(bank_wr_en), 32'(m_wr));
    check("busy", 32'(busy), 32'(m_wr));
    if (m_wr || m_rst) begin
      check("bank_in", 32'(bank_in), 32'(m_in));
      check("grant_idx", 32'(grant_idx), 32'(m_idx));
    end
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  ack;
    logic        wr;
    logic [7:0]  din;
    logic [1:0]  idx;
  } vec_t;

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    req = '0;
    req_data = '0;
    m_ack = '0; m_wr = 1'b0; m_in = '0; m_idx = 0; m_ptr = 0; m_rst = 1'b1;

`ifndef ARB_FIXED_PRIO_EN
    // Reset with all requesting, then rotation 0,1,2,3,0,... including the 3->0 wrap.
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 4'hF, 32'h44332211, 4'h0, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{1'b0, 4'hF, 32'h44332211, 4'h1, 1'b1, 8'h11, 2'd0});
    tbl.push_back('{1'b0, 4'hF, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1});
    tbl.push_back('{1'b0, 4'hF, 32'h44332211, 4'h4, 1'b1, 8'h33, 2'd2});
    tbl.push_back('{1'b0, 4'hF, 32'h44332211, 4'h8, 1'b1, 8'h44, 2'd3});
    tbl.push_back('{1'b0, 4'hF, 32'h44332211, 4'h1, 1'b1, 8'h11, 2'd0});
    tbl.push_back('{1'b0, 4'hF, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1});
    tbl.push_back('{1'b0, 4'hF, 32'h44332211, 4'h4, 1'b1, 8'h33, 2'd2});
    tbl.push_back('{1'b0, 4'hF, 32'h44332211, 4'h8, 1'b1, 8'h44, 2'd3});
    // Reset while writing for requester 3.
    tbl.push_back('{1'b1, 4'hF, 32'h44332211, 4'h0, 1'b0, 8'h00, 2'd0});
    // Single persistent requester 1: ack every other cycle.
    tbl.push_back('{1'b0, 4'h2, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1});
    tbl.push_back('{1'b0, 4'h2, 32'h44332211, 4'h0, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{1'b0, 4'h2, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1});
    tbl.push_back('{1'b0, 4'h2, 32'h44332211, 4'h0, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{1'b0, 4'h2, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1});
    // Reset with pointer at 2 must restore requester 0 as highest priority.
    tbl.push_back('{1'b1, 4'h0, 32'h44332211, 4'h0, 1'b0, 8'h00, 2'd0});
    tbl.push_back('{1'b0, 4'hF, 32'h44332211, 4'h1, 1'b1, 8'h11, 2'd0});
    tbl.push_back('{1'b0, 4'hA, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1});
    tbl.push_back('{1'b0, 4'hA, 32'h44332211, 4'h8, 1'b1, 8'h44, 2'd3});
    tbl.push_back('{1'b0, 4'hA, 32'h44332211, 4'h2, 1'b1, 8'h22, 2'd1});
    tbl.push_back('{1'b0, 4'h0, 32'h44332211, 4'h0, 1'b0, 8'h00, 2'd0});

    foreach (tbl[r]) begin
      rst = tbl[r].rst;
      req = tbl[r].req;
      req_data = tbl[r].data;
      step();
      check($sformatf("tbl%0d_ack", r), 32'(ack), 32'(tbl[r].ack));
      check($sformatf("tbl%0d_wr", r), 32'(bank_wr_en), 32'(tbl[r].wr));
      if (tbl[r].wr || tbl[r].rst) begin
        check($sformatf("tbl%0d_in", r), 32'(bank_in), 32'(tbl[r].din));
        check($sformatf("tbl%0d_idx", r), 32'(grant_idx), 32'(tbl[r].idx));
      end
    end

    // Single request from requester 2, then the bank holds its data.
    req = 4'b0100;
    req_data = 32'h44A52211;
    step();
    check("single_ack", 32'(ack), 32'h4);
    check("single_in", 32'(bank_in), 32'hA5);
    check("single_idx", 32'(grant_idx), 32'd2);
    req = 4'b0000;
    step();
    check("single_bank", 32'(bank_q), 32'hA5);
`else
    rst = 1'b1;
    step();
    rst = 1'b0;
    req = 4'b1010;
    req_data = 32'h44332211;
    for (int i = 0; i < 4; i++) begin
      step();
      check("fixed_ack", 32'(ack), (i % 2 == 0) ? 32'h2 : 32'h8);
    end
    req = 4'b0000;
    step();
`endif

    // Randomized requesters obeying the handshake.
    rst = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && m_ack[i]) begin
          if ($urandom_range(1, 0) == 1) req_data[i*W +: W] = W'($urandom);
          else req[i] = 1'b0;
        end else if (!req[i] && $urandom_range(2, 0) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom);
        end
      end
      rst = ($urandom_range(99, 0) == 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
